// File: rtl/adc_packet_framer.sv
// rtl/adc_packet_framer.sv - frames buffered ADC bytes into header+payload packets with an inter-packet gap
// Define FRAMER_CRC_EN to append a CRC-16-CCITT trailer over the payload bytes.
module adc_packet_framer #(
  parameter int unsigned PAYLOAD_BYTES = 1024,
  parameter int unsigned LEVEL_W       = 16,
  parameter int unsigned GAP_CYCLES    = 12,
  parameter logic [15:0] MAGIC         = 16'hADC1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [7:0]         fifo_dout,
  input  logic               fifo_empty,
  input  logic [LEVEL_W-1:0] fifo_level,
  output logic               fifo_rd_en,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               tx_last,
  output logic [31:0]        seq_num,
  output logic               busy,
  output logic               underrun
);

  localparam logic [15:0] LEN      = 16'(PAYLOAD_BYTES);
  localparam logic [15:0] LAST_IDX = 16'(PAYLOAD_BYTES - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAYLOAD,
`ifdef FRAMER_CRC_EN
    TRAILER,
`endif
    GAP
  } state_t;

  state_t      state;
  logic [63:0] hdr_sr;
  logic [2:0]  hdr_idx;
  logic [15:0] pay_cnt;
  logic [15:0] gap_cnt;
  logic [31:0] level_32;
  logic        level_ok;
  logic        pay_last;
  logic        xfer;

  assign level_32   = 32'(fifo_level);
  assign level_ok   = level_32 >= PAYLOAD_BYTES;
  assign pay_last   = pay_cnt == LAST_IDX;
  assign xfer       = tx_valid & tx_ready;
  assign fifo_rd_en = (state == PAYLOAD) & tx_ready & ~fifo_empty;
  assign busy       = state != IDLE;

`ifdef FRAMER_CRC_EN
  logic [15:0] crc;
  logic        trl_idx;

  function automatic logic [15:0] crc_step(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    c = c_in ^ {d, 8'h00};
    for (int i = 0; i < 8; i++)
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction
`endif

  // Header comes from a shift register; payload passes straight through from the FWFT FIFO.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_last  = 1'b0;
    case (state)
      HDR: begin
        tx_valid = 1'b1;
        tx_data  = hdr_sr[63:56];
      end
      PAYLOAD: begin
        tx_valid = ~fifo_empty;
        tx_data  = fifo_dout;
`ifndef FRAMER_CRC_EN
        tx_last  = ~fifo_empty & pay_last;
`endif
      end
`ifdef FRAMER_CRC_EN
      TRAILER: begin
        tx_valid = 1'b1;
        tx_data  = trl_idx ? crc[7:0] : crc[15:8];
        tx_last  = trl_idx;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hdr_sr   <= 64'd0;
      hdr_idx  <= 3'd0;
      pay_cnt  <= 16'd0;
      gap_cnt  <= 16'd0;
      seq_num  <= 32'd0;
      underrun <= 1'b0;
`ifdef FRAMER_CRC_EN
      crc      <= 16'd0;
      trl_idx  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (en && level_ok) begin
            state   <= HDR;
            hdr_sr  <= {MAGIC, seq_num, LEN};
            hdr_idx <= 3'd0;
            pay_cnt <= 16'd0;
`ifdef FRAMER_CRC_EN
            crc     <= 16'hFFFF;
`endif
          end
        end
        HDR: begin
          if (xfer) begin
            hdr_sr  <= {hdr_sr[55:0], 8'h00};
            hdr_idx <= hdr_idx + 3'd1;
            if (hdr_idx == 3'd7)
              state <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (fifo_empty)
            underrun <= 1'b1;
          if (xfer) begin
            pay_cnt <= pay_cnt + 16'd1;
`ifdef FRAMER_CRC_EN
            crc     <= crc_step(crc, fifo_dout);
            if (pay_last) begin
              state   <= TRAILER;
              trl_idx <= 1'b0;
            end
`else
            if (pay_last) begin
              state   <= GAP;
              gap_cnt <= 16'd0;
              seq_num <= seq_num + 32'd1;
            end
`endif
          end
        end
`ifdef FRAMER_CRC_EN
        TRAILER: begin
          if (xfer) begin
            trl_idx <= 1'b1;
            if (trl_idx) begin
              state   <= GAP;
              gap_cnt <= 16'd0;
              seq_num <= seq_num + 32'd1;
            end
          end
        end
`endif
        GAP: begin
          if (gap_cnt == GAP_LAST)
            state <= IDLE;
          else
            gap_cnt <= gap_cnt + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_packet_framer.sv
// tb/tb_adc_packet_framer.sv - scoreboard bench for adc_packet_framer with a model FWFT FIFO
module tb_adc_packet_framer;
`ifdef FRAMER_CRC_EN
  localparam int P = 9;
  localparam logic [7:0] BASE0 = 8'h31;
  localparam int PLEN = P + 10;
`else
  localparam int P = 16;
  localparam logic [7:0] BASE0 = 8'h00;
  localparam int PLEN = P + 8;
`endif
  localparam int G = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        tx_ready = 1'b1;
  logic        force_empty = 1'b0;
  logic        fifo_flush = 1'b0;
  logic [7:0]  fifo_dout;
  logic        fifo_empty;
  logic [15:0] fifo_level;
  logic        fifo_rd_en;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_last;
  logic [31:0] seq_num;
  logic        busy;
  logic        underrun;

  logic [7:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic [7:0] pl [P];

  typedef struct packed {logic [7:0] d; logic l;} exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int pkt_idx = 0;
  int idle_cnt = 0;
  int gaps_checked = 0;
  logic after_last = 1'b0;
  logic stalled = 1'b0;
  logic [8:0] stall_v = 9'd0;

  adc_packet_framer #(.PAYLOAD_BYTES(P), .LEVEL_W(16), .GAP_CYCLES(G), .MAGIC(16'hADC1)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_level(fifo_level), .fifo_rd_en(fifo_rd_en), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_last(tx_last), .seq_num(seq_num), .busy(busy), .underrun(underrun)
  );

  always #4 clk = ~clk;

  assign fifo_dout  = mem[rd_ptr[7:0]];
  assign fifo_empty = (wr_ptr == rd_ptr) || force_empty;
  assign fifo_level = 16'(wr_ptr - rd_ptr);

  always @(posedge clk) begin
    if (fifo_flush) rd_ptr <= wr_ptr;
    else if (fifo_rd_en) rd_ptr <= rd_ptr + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Bit-serial reference CRC-16-CCITT, MSB first.
  function automatic logic [15:0] crc_model(input int n);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int k = 0; k < n; k++)
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ pl[k][b];
        c = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gen_payload(input logic [7:0] base);
    for (int i = 0; i < P; i++) pl[i] = base + 8'(i);
  endtask

  task automatic push_fifo(input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      mem[wr_ptr[7:0]] = pl[i];
      wr_ptr = wr_ptr + 1;
    end
  endtask

  task automatic expect_packet(input logic [31:0] seq);
    logic [15:0] len;
    logic [15:0] crc;
    len = 16'(P);
    exp_q.push_back({8'hAD, 1'b0});
    exp_q.push_back({8'hC1, 1'b0});
    exp_q.push_back({seq[31:24], 1'b0});
    exp_q.push_back({seq[23:16], 1'b0});
    exp_q.push_back({seq[15:8], 1'b0});
    exp_q.push_back({seq[7:0], 1'b0});
    exp_q.push_back({len[15:8], 1'b0});
    exp_q.push_back({len[7:0], 1'b0});
`ifdef FRAMER_CRC_EN
    for (int i = 0; i < P; i++) exp_q.push_back({pl[i], 1'b0});
    crc = crc_model(P);
    exp_q.push_back({crc[15:8], 1'b0});
    exp_q.push_back({crc[7:0], 1'b1});
`else
    crc = 16'h0000;
    for (int i = 0; i < P; i++) exp_q.push_back({pl[i], i == P - 1});
`endif
  endtask

  task automatic wait_idle(input int budget);
    logic done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      tick();
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    check("wait_idle_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_byte(input int idx);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < 300 && !hit; k++) begin
      if (tx_valid && pkt_idx == idx) hit = 1'b1;
      else tick();
    end
    check("wait_byte_timeout", {31'd0, hit}, 32'd1);
  endtask

  task automatic stall_at(input int idx);
    wait_byte(idx);
    tx_ready = 1'b0;
    tick();
    tick();
    tx_ready = 1'b1;
  endtask

  // Monitor: scoreboard pops on every transfer, plus handshake and gap checks.
  always @(negedge clk) begin
    if (rst) begin
      pkt_idx = 0;
      after_last = 1'b0;
      stalled = 1'b0;
    end else begin
      if (fifo_rd_en) check("rd_en_without_transfer", {31'd0, tx_valid & tx_ready}, 32'd1);
      if (stalled && tx_valid) check("stall_hold", {23'd0, tx_data, tx_last}, {23'd0, stall_v});
      stalled = tx_valid && !tx_ready;
      stall_v = {tx_data, tx_last};
      if (after_last && !tx_valid) idle_cnt++;
      if (after_last && tx_valid) begin
        if (gaps_checked == 0) check("gap_idle_clocks", idle_cnt, G + 1);
        gaps_checked++;
        after_last = 1'b0;
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("byte_data", {24'd0, tx_data}, {24'd0, e.d});
          check("byte_last", {31'd0, tx_last}, {31'd0, e.l});
        end
        pkt_idx++;
        if (tx_last) begin
          pkt_idx = 0;
          after_last = 1'b1;
          idle_cnt = 0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bad;
    logic started;
    repeat (3) tick();
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_tx_last", {31'd0, tx_last}, 32'd0);
    check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_seq", seq_num, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    rst = 1'b0;

    // Two packets buffered, held off while en=0, then sent back to back.
    gen_payload(BASE0);
    push_fifo(0, P);
    expect_packet(32'd0);
    gen_payload(8'h40);
    push_fifo(0, P);
    expect_packet(32'd1);
    repeat (5) tick();
    check("en_low_idle", {31'd0, busy}, 32'd0);
    en = 1'b1;
    bad = 1'b1;
    for (int k = 0; k < 300 && bad; k++) begin
      tick();
      if (exp_q.size() <= PLEN) bad = 1'b0;
    end
    check("first_packet_seq", seq_num, 32'd1);
    wait_idle(300);
    check("two_packet_seq", seq_num, 32'd2);

    // Level gating: one byte short must not start.
    gen_payload(8'h80);
    push_fifo(0, P - 1);
    expect_packet(32'd2);
    bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (tx_valid || fifo_rd_en) bad = 1'b1;
    end
    check("level_gate_idle", {31'd0, bad}, 32'd0);
    push_fifo(P - 1, 1);
    started = 1'b0;
    for (int k = 0; k < 2 && !started; k++) begin
      tick();
      if (tx_valid) started = 1'b1;
    end
    check("level_start", {31'd0, started}, 32'd1);

    // Backpressure on header byte 3 and payload byte 5 of the same packet.
    stall_at(3);
    stall_at(8 + 5);
    wait_idle(300);
    check("bp_seq", seq_num, 32'd3);

    // Underrun bubble mid-payload.
    gen_payload(8'hC0);
    push_fifo(0, P);
    expect_packet(32'd3);
    wait_byte(8 + 7);
    force_empty = 1'b1;
    repeat (3) tick();
    force_empty = 1'b0;
    check("underrun_set", {31'd0, underrun}, 32'd1);
    wait_idle(300);
    check("underrun_sticky", {31'd0, underrun}, 32'd1);
    check("underrun_seq", seq_num, 32'd4);

    // Reset mid-payload.
    gen_payload(8'h20);
    push_fifo(0, P);
    expect_packet(32'd4);
    wait_byte(8 + 7);
    rst = 1'b1;
    fifo_flush = 1'b1;
    tick();
    rst = 1'b0;
    fifo_flush = 1'b0;
    exp_q.delete();
    check("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_seq", seq_num, 32'd0);
    check("midrst_underrun", {31'd0, underrun}, 32'd0);
    gen_payload(8'h50);
    push_fifo(0, P);
    expect_packet(32'd0);
    wait_idle(300);
    check("post_rst_seq", seq_num, 32'd1);

    // Sequence number wrap.
    force dut.seq_num = 32'hFFFF_FFFF;
    tick();
    release dut.seq_num;
    tick();
    check("seq_preset", seq_num, 32'hFFFF_FFFF);
    gen_payload(8'hE0);
    push_fifo(0, P);
    expect_packet(32'hFFFF_FFFF);
    wait_idle(300);
    check("seq_wrap", seq_num, 32'd0);

    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
